// File: rtl/product_accumulator.sv
// Sums a programmed number of signed products into a wider signed accumulator
// and hands one result per job downstream, flagging any overflow seen in the job.
module product_accumulator #(
    parameter int PROD_W   = 16,
    parameter int ACC_W    = 24,
    parameter int LEN_W    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod_data,
    output logic              prod_ready,
    output logic              acc_valid,
    output logic [ACC_W-1:0]  acc_data,
    output logic              acc_ovf,
    input  logic              acc_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    localparam int EXT_W = ACC_W + 1 - PROD_W;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic               ovf_q,   ovf_d;

    logic [ACC_W:0]     sum;
    logic               sum_ovf;
    logic [ACC_W-1:0]   sum_fit;

    // One guard bit above the accumulator: overflow shows as the top two bits disagreeing.
    assign sum     = {acc_q[ACC_W-1], acc_q} + {{EXT_W{prod_data[PROD_W-1]}}, prod_data};
    assign sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];

    always_comb begin
        sum_fit = sum[ACC_W-1:0];
        if (SATURATE && sum_ovf) begin
            sum_fit = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    count_d = len;
                    state_d = (len != '0) ? S_ACCUM : S_DONE;
                end
            end
            S_ACCUM: begin
                if (prod_valid && prod_ready) begin
                    acc_d   = sum_fit;
                    ovf_d   = ovf_q | sum_ovf;
                    count_d = count_q - LEN_W'(1);
                    if (count_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (acc_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        prod_ready = (state_q == S_ACCUM);
        acc_valid  = (state_q == S_DONE);
        busy       = (state_q != S_IDLE);
        acc_data   = acc_q;
        acc_ovf    = ovf_q;
    end

endmodule
